// File: rtl/instr_queue_dispatch_pkg.sv
// Shared types for the instruction-queue dispatcher: entry layout, instruction
// types and dispatch FSM states.
package instr_queue_dispatch_pkg;

    localparam int IQ_ADDR_W = 18;

    typedef enum logic [1:0] {
        INSTR_TYPE_RAM  = 2'd0,
        INSTR_TYPE_LOOP = 2'd1,
        INSTR_TYPE_ALU  = 2'd2,
        INSTR_TYPE_SYNC = 2'd3
    } instr_type_t;

    typedef struct packed {
        instr_type_t            instr_type;
        logic [IQ_ADDR_W-1:0]   cache_addr;
        logic [IQ_ADDR_W-1:0]   main_mem_addr;
        logic [IQ_ADDR_W-1:0]   d_cache_addr;
        logic [IQ_ADDR_W-1:0]   d_main_mem_addr;
    } queue_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEM_ROW = 2'd1,
        ST_EXEC    = 2'd2
    } disp_state_t;

endpackage

// File: rtl/instr_queue_dispatch_fifo.sv
// Circular FIFO holding queued entries; head stays readable until popped.
// A push while full is only taken when a pop frees the slot in the same cycle.
module instr_fifo #(
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = 3,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [WIDTH-1:0]     head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [LOG_DEPTH:0]   count_o
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG_DEPTH:0]   count_q;
    logic                 push_ok, pop_ok;

    assign full_o  = (count_q == (LOG_DEPTH+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/instr_queue_dispatch.sv
// Dispatches queued entries: RAM entries become TILE_ROWS strided row requests,
// everything else is presented once on the exec port. Address width is IQ_ADDR_W.
module instr_queue_dispatch
    import instr_queue_dispatch_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = 3,
    parameter int TILE_ROWS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 queue_we,
    input  logic [1:0]           queue_instr_type,
    input  logic [IQ_ADDR_W-1:0] cache_addr,
    input  logic [IQ_ADDR_W-1:0] main_mem_addr,
    input  logic [IQ_ADDR_W-1:0] d_cache_addr,
    input  logic [IQ_ADDR_W-1:0] d_main_mem_addr,
    output logic                 queue_full,
    output logic                 queue_overflow,
    output logic                 busy,
    output logic                 mem_req,
    output logic [IQ_ADDR_W-1:0] mem_cache_addr,
    output logic [IQ_ADDR_W-1:0] mem_main_addr,
    input  logic                 mem_ack,
    output logic                 exec_valid,
    output logic [1:0]           exec_instr_type,
    output logic [IQ_ADDR_W-1:0] exec_cache_addr,
    input  logic                 exec_ready
);

    localparam int ROW_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TILE_ROWS - 1);

    queue_entry_t         push_entry, head;
    logic                 fifo_full, fifo_empty, pop;
    logic [LOG_DEPTH:0]   fifo_count;

    disp_state_t          state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [IQ_ADDR_W-1:0] cur_cache_q, cur_cache_d, cur_main_q, cur_main_d;
    logic                 overflow_q, overflow_d;

    assign push_entry = '{instr_type:      instr_type_t'(queue_instr_type),
                          cache_addr:      cache_addr,
                          main_mem_addr:   main_mem_addr,
                          d_cache_addr:    d_cache_addr,
                          d_main_mem_addr: d_main_mem_addr};

    instr_fifo #(
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH),
        .WIDTH     ($bits(queue_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (queue_we),
        .pop_i   (pop),
        .data_i  (push_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            cur_cache_q <= '0;
            cur_main_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cur_cache_q <= cur_cache_d;
            cur_main_q  <= cur_main_d;
            overflow_q  <= overflow_d;
        end
    end

    // Head stays in the FIFO while in flight, so its strides are read directly.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cur_cache_d = cur_cache_q;
        cur_main_d  = cur_main_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head.instr_type == INSTR_TYPE_RAM) begin
                        state_d     = ST_MEM_ROW;
                        row_d       = '0;
                        cur_cache_d = head.cache_addr;
                        cur_main_d  = head.main_mem_addr;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_MEM_ROW: begin
                if (mem_ack) begin
                    if (row_q == LAST_ROW) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        row_d       = row_q + 1'b1;
                        cur_cache_d = cur_cache_q + head.d_cache_addr;
                        cur_main_d  = cur_main_q + head.d_main_mem_addr;
                    end
                end
            end
            ST_EXEC: begin
                if (exec_ready) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overflow_d = overflow_q | (queue_we & fifo_full & ~pop);
    end

    assign queue_full      = (fifo_count == (LOG_DEPTH+1)'(DEPTH));
    assign queue_overflow  = overflow_q;
    assign busy            = ~fifo_empty | (state_q != ST_IDLE);
    assign mem_req         = (state_q == ST_MEM_ROW);
    assign mem_cache_addr  = mem_req ? cur_cache_q : '0;
    assign mem_main_addr   = mem_req ? cur_main_q : '0;
    assign exec_valid      = (state_q == ST_EXEC);
    assign exec_instr_type = exec_valid ? 2'(head.instr_type) : 2'b00;
    assign exec_cache_addr = exec_valid ? head.cache_addr : '0;

endmodule

// File: tb/tb_instr_queue_dispatch.sv
// Directed bench for instr_queue_dispatch: row expansion, stalls, full/overflow,
// exec path, push-on-pop at full, async reset mid-transfer and stride wrap.
module tb_instr_queue_dispatch;
    import instr_queue_dispatch_pkg::*;

    logic        clk, reset, queue_we, mem_ack, exec_ready;
    logic [1:0]  queue_instr_type;
    logic [17:0] cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr;
    logic        queue_full, queue_overflow, busy, mem_req, exec_valid;
    logic [17:0] mem_cache_addr, mem_main_addr, exec_cache_addr;
    logic [1:0]  exec_instr_type;

    int n_cmp = 0;
    int n_fail = 0;

    instr_queue_dispatch dut (
        .clk(clk), .reset(reset), .queue_we(queue_we), .queue_instr_type(queue_instr_type),
        .cache_addr(cache_addr), .main_mem_addr(main_mem_addr),
        .d_cache_addr(d_cache_addr), .d_main_mem_addr(d_main_mem_addr),
        .queue_full(queue_full), .queue_overflow(queue_overflow), .busy(busy),
        .mem_req(mem_req), .mem_cache_addr(mem_cache_addr), .mem_main_addr(mem_main_addr),
        .mem_ack(mem_ack), .exec_valid(exec_valid), .exec_instr_type(exec_instr_type),
        .exec_cache_addr(exec_cache_addr), .exec_ready(exec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [17:0] c, input logic [17:0] m,
                        input logic [17:0] dc, input logic [17:0] dm);
        queue_we = 1'b1; queue_instr_type = t;
        cache_addr = c; main_mem_addr = m; d_cache_addr = dc; d_main_mem_addr = dm;
        tick();
        queue_we = 1'b0;
    endtask

    task automatic chk_row(input string tag, input logic [17:0] c, input logic [17:0] m);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_c"}, 32'(mem_cache_addr), 32'(c));
        chk({tag, "_m"}, 32'(mem_main_addr), 32'(m));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_ev"}, 32'(exec_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_full"}, 32'(queue_full), 32'd0);
        chk({tag, "_ovf"}, 32'(queue_overflow), 32'd0);
        chk({tag, "_addr"}, 32'({mem_cache_addr, mem_main_addr} == '0), 32'd1);
        chk({tag, "_exaddr"}, 32'({exec_cache_addr, exec_instr_type} == '0), 32'd1);
    endtask

    // Entry sits in MEM_ROW at row 0 on entry; leaves one cycle into the next entry.
    task automatic drain_one(input string tag, input logic [17:0] c, input logic [17:0] m);
        chk_row(tag, c, m);
        mem_ack = 1'b1;
        repeat (4) tick();
        mem_ack = 1'b0;
        chk({tag, "_idle"}, 32'(mem_req), 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b0; queue_we = 1'b0; mem_ack = 1'b0; exec_ready = 1'b0;
        queue_instr_type = 2'd0; cache_addr = '0; main_mem_addr = '0;
        d_cache_addr = '0; d_main_mem_addr = '0;
        tick(); tick();
        chk_zero("rst");
        reset = 1'b1;
        tick();

        // 1: ack every cycle
        push(INSTR_TYPE_RAM, 18'd0, 18'd3, 18'd2, 18'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_noreq", 32'(mem_req), 32'd0);
        tick();
        chk_row("t1_r0", 18'd0, 18'd3);
        mem_ack = 1'b1;
        tick(); chk_row("t1_r1", 18'd2, 18'd3);
        tick(); chk_row("t1_r2", 18'd4, 18'd3);
        tick(); chk_row("t1_r3", 18'd6, 18'd3);
        tick();
        mem_ack = 1'b0;
        chk("t1_done_req", 32'(mem_req), 32'd0);
        chk("t1_done_busy", 32'(busy), 32'd0);

        // 2: stall on row 1
        push(INSTR_TYPE_RAM, 18'h10, 18'h100, 18'd4, 18'd8);
        tick();
        chk_row("t2_r0", 18'h10, 18'h100);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_row("t2_hold", 18'h14, 18'h108);
            tick();
        end
        chk_row("t2_hold", 18'h14, 18'h108);
        mem_ack = 1'b1;
        tick(); chk_row("t2_r2", 18'h18, 18'h110);
        tick(); chk_row("t2_r3", 18'h1C, 18'h118);
        tick();
        mem_ack = 1'b0;
        chk("t2_done", 32'(mem_req), 32'd0);

        // 4: exec path with delayed ready
        push(INSTR_TYPE_LOOP, 18'h55, 18'h0, 18'h0, 18'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t4_valid", 32'(exec_valid), 32'd1);
            chk("t4_type", 32'(exec_instr_type), 32'(INSTR_TYPE_LOOP));
            chk("t4_addr", 32'(exec_cache_addr), 32'h55);
            chk("t4_nomem", 32'(mem_req), 32'd0);
            tick();
        end
        exec_ready = 1'b1; tick(); exec_ready = 1'b0;
        chk("t4_pop_valid", 32'(exec_valid), 32'd0);
        chk("t4_pop_busy", 32'(busy), 32'd0);

        // 7: cache stride wraps at 2^18
        push(INSTR_TYPE_RAM, 18'h3FFFE, 18'h0, 18'h1, 18'h0);
        tick();
        mem_ack = 1'b1;
        chk_row("t7_r0", 18'h3FFFE, 18'h0);
        tick(); chk_row("t7_r1", 18'h3FFFF, 18'h0);
        tick(); chk_row("t7_r2", 18'h00000, 18'h0);
        tick(); chk_row("t7_r3", 18'h00001, 18'h0);
        tick();
        mem_ack = 1'b0;
        chk("t7_done", 32'(busy), 32'd0);

        // 3: nine pushes, no acks
        for (int i = 0; i < 9; i++) begin
            push(INSTR_TYPE_RAM, 18'(i * 16'h100), 18'(i), 18'd1, 18'd0);
            if (i == 6) chk("t3_not_full", 32'(queue_full), 32'd0);
            if (i == 7) chk("t3_full", 32'(queue_full), 32'd1);
        end
        chk("t3_full9", 32'(queue_full), 32'd1);
        chk("t3_ovf", 32'(queue_overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drain_one("t3_drain", 18'(i * 16'h100), 18'(i));
            if (i == 0) chk("t3_unfull", 32'(queue_full), 32'd0);
        end
        chk("t3_empty", 32'(busy), 32'd0);
        chk("t3_ovf_sticky", 32'(queue_overflow), 32'd1);

        reset = 1'b0; tick();
        chk_zero("rst2");
        reset = 1'b1; tick();

        // 5: push lands on the same cycle as the final ack while full
        for (int i = 0; i < 8; i++) push(INSTR_TYPE_RAM, 18'(16'h1000 + i), 18'(8'h20 + i), 18'd0, 18'd0);
        chk("t5_full", 32'(queue_full), 32'd1);
        mem_ack = 1'b1;
        tick(); tick(); tick();
        push(INSTR_TYPE_RAM, 18'h2000, 18'h2F, 18'd0, 18'd0);
        mem_ack = 1'b0;
        chk("t5_full_kept", 32'(queue_full), 32'd1);
        chk("t5_no_ovf", 32'(queue_overflow), 32'd0);
        tick();
        for (int i = 1; i < 8; i++) drain_one("t5_drain", 18'(16'h1000 + i), 18'(8'h20 + i));
        drain_one("t5_new", 18'h2000, 18'h2F);
        chk("t5_empty", 32'(busy), 32'd0);

        // 6: async reset during row 2
        push(INSTR_TYPE_RAM, 18'h40, 18'h80, 18'd1, 18'd1);
        tick();
        mem_ack = 1'b1; tick(); tick(); mem_ack = 1'b0;
        chk_row("t6_r2", 18'h42, 18'h82);
        #2 reset = 1'b0;
        #1 chk_zero("t6_async");
        tick();
        reset = 1'b1;
        tick();
        chk("t6_flushed", 32'(busy), 32'd0);
        push(INSTR_TYPE_RAM, 18'h77, 18'h99, 18'd1, 18'd1);
        tick();
        drain_one("t6_fresh", 18'h77, 18'h99);
        chk("t6_done", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
